// File: rtl/sh1_dual_port_ram_be.sv
// True dual-port RAM with byte enables, clear-after-reset sequencer and A-priority write merge.
// Read latency READ_LATENCY (0 or 1); no backpressure, but accesses are dropped while ready=0.
module sh1_dual_port_ram_be #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 1 << ADDR_WIDTH,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    ready,
    output logic                    collision,
    input  logic                    a_en,
    input  logic                    a_we,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    output logic                    a_rvalid,
    input  logic                    b_en,
    input  logic                    b_we,
    input  logic [DATA_WIDTH/8-1:0] b_be,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]   b_wdata,
    output logic [DATA_WIDTH-1:0]   b_rdata,
    output logic                    b_rvalid
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           clr_cnt_q, clr_cnt_d;
    logic                    collision_q, collision_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    a_inr, b_inr, a_acc, b_acc, a_wr, b_wr;
    logic [IW-1:0]           a_idx, b_idx;
    logic [DATA_WIDTH-1:0]   a_old, b_old, a_mask, b_mask, a_new, b_new;

    assign ready     = (state_q == S_READY);
    assign collision = collision_q;

    always_comb begin
        a_inr = ({1'b0, a_addr} < (ADDR_WIDTH+1)'(DEPTH));
        b_inr = ({1'b0, b_addr} < (ADDR_WIDTH+1)'(DEPTH));
        a_idx = a_addr[IW-1:0];
        b_idx = b_addr[IW-1:0];
        a_old = a_inr ? mem_q[a_idx] : '0;
        b_old = b_inr ? mem_q[b_idx] : '0;
        a_acc = ready & a_en;
        b_acc = ready & b_en;
        a_wr  = a_acc & a_we & a_inr;
        b_wr  = b_acc & b_we & b_inr;
        a_mask = '0;
        b_mask = '0;
        for (int i = 0; i < NB; i++) begin
            a_mask[i*8 +: 8] = {8{a_be[i]}};
            b_mask[i*8 +: 8] = {8{b_be[i]}};
        end
        // Own-port view of the word after this cycle's write (write-first reads).
        a_new = a_wr ? ((a_old & ~a_mask) | (a_wdata & a_mask)) : a_old;
        b_new = b_wr ? ((b_old & ~b_mask) | (b_wdata & b_mask)) : b_old;
        collision_d = a_wr & b_wr & (a_addr == b_addr) & (|(a_be & b_be));
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == IW'(DEPTH - 1)) begin
                    state_d   = S_READY;
                    clr_cnt_d = '0;
                end
            end
            default: state_d = S_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
            clr_cnt_q   <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            collision_q <= collision_d;
        end
    end

    // Port A is applied last so it owns bytes both ports enable on the same word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_CLEAR) begin
                mem_q[clr_cnt_q] <= '0;
            end
            for (int i = 0; i < NB; i++) begin
                if (b_wr && b_be[i]) mem_q[b_idx][i*8 +: 8] <= b_wdata[i*8 +: 8];
                if (a_wr && a_be[i]) mem_q[a_idx][i*8 +: 8] <= a_wdata[i*8 +: 8];
            end
        end
    end

    if (READ_LATENCY == 0) begin : g_comb_rd
        assign a_rdata  = a_old;
        assign b_rdata  = b_old;
        assign a_rvalid = a_acc;
        assign b_rvalid = b_acc;
    end else begin : g_reg_rd
        logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
        logic                  a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;

        always_comb begin
            a_rvalid_d = a_acc;
            b_rvalid_d = b_acc;
            a_rdata_d  = a_rdata_q;
            b_rdata_d  = b_rdata_q;
            if (a_acc) a_rdata_d = (RDW_MODE == 0) ? a_new : a_old;
            if (b_acc) b_rdata_d = (RDW_MODE == 0) ? b_new : b_old;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                a_rdata_q  <= '0;
                b_rdata_q  <= '0;
                a_rvalid_q <= 1'b0;
                b_rvalid_q <= 1'b0;
            end else begin
                a_rdata_q  <= a_rdata_d;
                b_rdata_q  <= b_rdata_d;
                a_rvalid_q <= a_rvalid_d;
                b_rvalid_q <= b_rvalid_d;
            end
        end

        assign a_rdata  = a_rdata_q;
        assign b_rdata  = b_rdata_q;
        assign a_rvalid = a_rvalid_q;
        assign b_rvalid = b_rvalid_q;
    end

endmodule

// File: tb/tb_sh1_dual_port_ram_be.sv
// Scoreboard bench: write-first, read-first (DEPTH=16, registered) and combinational (DEPTH=12) instances.
// Stimulus pushes expected read words per port; a negedge monitor pops and compares on rvalid.
module tb_sh1_dual_port_ram_be;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_en, a_we, b_en, b_we, c_en, c_we;
    logic [3:0]  a_be, b_be, c_be;
    logic [4:0]  a_addr, b_addr;
    logic [3:0]  c_addr;
    logic [31:0] a_wdata, b_wdata, c_wdata;

    logic        wf_ready, wf_coll, wf_arv, wf_brv;
    logic        rf_ready, rf_coll, rf_arv, rf_brv;
    logic        c_ready, c_coll, c_arv, c_brv;
    logic [31:0] wf_ard, wf_brd, rf_ard, rf_brd, c_ard, c_brd;

    sh1_dual_port_ram_be #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(1),
                           .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_wf (
        .clk(clk), .rst(rst), .ready(wf_ready), .collision(wf_coll),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(wf_ard), .a_rvalid(wf_arv),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(wf_brd), .b_rvalid(wf_brv));

    sh1_dual_port_ram_be #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(1),
                           .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_rf (
        .clk(clk), .rst(rst), .ready(rf_ready), .collision(rf_coll),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(rf_ard), .a_rvalid(rf_arv),
        .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(rf_brd), .b_rvalid(rf_brv));

    sh1_dual_port_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(12), .READ_LATENCY(0),
                           .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_c (
        .clk(clk), .rst(rst), .ready(c_ready), .collision(c_coll),
        .a_en(c_en), .a_we(c_we), .a_be(c_be), .a_addr(c_addr), .a_wdata(c_wdata),
        .a_rdata(c_ard), .a_rvalid(c_arv),
        .b_en(1'b0), .b_we(1'b0), .b_be(4'h0), .b_addr(4'h0), .b_wdata(32'h0),
        .b_rdata(c_brd), .b_rvalid(c_brv));

    typedef struct {
        int          due;
        logic [31:0] dat;
        bit          chk;
    } exp_t;

    // Queue ids: 0 wf.A, 1 wf.B, 2 rf.A, 3 rf.B, 4 c.A, 5 c.B
    exp_t qs[6][$];
    int   coll_q[$];
    int   cyc = 0;
    int   rst_cyc = 0;
    bit   rst_seen = 1'b0;
    bit   done = 1'b0;
    int   errs = 0;
    int   checks = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            rst_cyc  <= cyc + 1;
            rst_seen <= 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input int id, input int due, input logic [31:0] d, input bit c);
        exp_t e;
        e.due = due;
        e.dat = d;
        e.chk = c;
        qs[id].push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        a_en = 1'b0; a_we = 1'b0; b_en = 1'b0; b_we = 1'b0; c_en = 1'b0; c_we = 1'b0;
    endtask

    task automatic acc_a(input logic we, input logic [3:0] be, input logic [4:0] addr,
                         input logic [31:0] wd, input logic [31:0] e_wf, input logic [31:0] e_rf,
                         input bit c);
        a_en = 1'b1; a_we = we; a_be = be; a_addr = addr; a_wdata = wd;
        push(0, cyc + 1, e_wf, c);
        push(2, cyc + 1, e_rf, c);
    endtask

    task automatic acc_b(input logic we, input logic [3:0] be, input logic [4:0] addr,
                         input logic [31:0] wd, input logic [31:0] e_wf, input logic [31:0] e_rf,
                         input bit c);
        b_en = 1'b1; b_we = we; b_be = be; b_addr = addr; b_wdata = wd;
        push(1, cyc + 1, e_wf, c);
        push(3, cyc + 1, e_rf, c);
    endtask

    task automatic acc_c(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                         input logic [31:0] e);
        c_en = 1'b1; c_we = we; c_be = 4'hF; c_addr = addr; c_wdata = wd;
        push(4, cyc, e, 1'b1);
    endtask

    task automatic ignored_traffic();
        a_en = 1'b1; a_we = 1'b1; a_be = 4'hF; a_addr = 5'd2; a_wdata = 32'h5A5A5A5A;
        b_en = 1'b1; b_we = 1'b0; b_addr = 5'd2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        a_en = 0; a_we = 0; a_be = 0; a_addr = 0; a_wdata = 0;
        b_en = 0; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0;
        c_en = 0; c_we = 0; c_be = 0; c_addr = 0; c_wdata = 0;
        step(); step();
        rst = 1'b0;
        repeat (16) step();

        // Preload all ones, then a one-cycle reset must clear everything.
        for (int i = 0; i < 16; i++) begin
            acc_a(1'b1, 4'hF, 5'(i), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (16) step();
        for (int i = 0; i < 16; i++) begin
            acc_a(1'b0, 4'h0, 5'(i), 32'h0, 32'h0, 32'h0, 1'b1);
            acc_b(1'b0, 4'h0, 5'(15 - i), 32'h0, 32'h0, 32'h0, 1'b1);
            step();
        end

        // Byte-enable merge.
        acc_a(1'b1, 4'hF, 5'd5, 32'h11223344, 32'h11223344, 32'h00000000, 1'b1); step();
        acc_a(1'b1, 4'b0101, 5'd5, 32'hAABBCCDD, 32'h11BB33DD, 32'h11223344, 1'b1); step();
        acc_b(1'b0, 4'h0, 5'd5, 32'h0, 32'h11BB33DD, 32'h11BB33DD, 1'b1); step();

        // Read-during-write, same port and cross port.
        acc_a(1'b1, 4'hF, 5'd3, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1); step();
        acc_a(1'b1, 4'hF, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF, 32'h12345678, 1'b1);
        acc_b(1'b0, 4'h0, 5'd3, 32'h0, 32'h12345678, 32'h12345678, 1'b1);
        step();
        acc_b(1'b0, 4'h0, 5'd3, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1); step();

        // Overlapping write collision on word 7, then disjoint enables on word 8.
        acc_a(1'b1, 4'b0011, 5'd7, 32'hAAAAAAAA, 32'h0, 32'h0, 1'b0);
        acc_b(1'b1, 4'b0110, 5'd7, 32'hBBBBBBBB, 32'h0, 32'h0, 1'b0);
        coll_q.push_back(cyc + 1);
        step();
        acc_a(1'b0, 4'h0, 5'd7, 32'h0, 32'h00BBAAAA, 32'h00BBAAAA, 1'b1); step();
        acc_a(1'b1, 4'b0011, 5'd8, 32'hAAAAAAAA, 32'h0, 32'h0, 1'b0);
        acc_b(1'b1, 4'b1100, 5'd8, 32'hBBBBBBBB, 32'h0, 32'h0, 1'b0);
        step();
        acc_b(1'b0, 4'h0, 5'd8, 32'h0, 32'hBBBBAAAA, 32'hBBBBAAAA, 1'b1); step();

        // Out-of-range address 20 on a 16-word array; word 4 must not alias.
        acc_a(1'b1, 4'hF, 5'd20, 32'h00000055, 32'h0, 32'h0, 1'b1); step();
        acc_a(1'b0, 4'h0, 5'd20, 32'h0, 32'h0, 32'h0, 1'b1);
        acc_b(1'b0, 4'h0, 5'd4, 32'h0, 32'h0, 32'h0, 1'b1);
        step();

        // Reset again at clear count 9 while hammering the ports.
        rst = 1'b1;
        ignored_traffic();
        step();
        rst = 1'b0;
        repeat (9) begin
            ignored_traffic();
            step();
        end
        rst = 1'b1;
        ignored_traffic();
        step();
        rst = 1'b0;
        repeat (16) begin
            ignored_traffic();
            step();
        end
        acc_a(1'b0, 4'h0, 5'd2, 32'h0, 32'h0, 32'h0, 1'b1);
        acc_b(1'b0, 4'h0, 5'd3, 32'h0, 32'h0, 32'h0, 1'b1);
        step();

        // Combinational instance, 12 words.
        acc_c(1'b1, 4'd3, 32'h00000055, 32'h0); step();
        acc_c(1'b0, 4'd3, 32'h0, 32'h00000055); step();
        acc_c(1'b1, 4'd13, 32'h00000055, 32'h0); step();
        acc_c(1'b0, 4'd13, 32'h0, 32'h0); step();
        acc_c(1'b0, 4'd1, 32'h0, 32'h0); step();
        acc_c(1'b0, 4'd3, 32'h0, 32'h00000055); step();

        step(); step();
        done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by cyc %0d, required end well before", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic chk_bit(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s cyc %0d: got %0b required %0b", nm, cyc, got, exp);
        end
    endtask

    task automatic chk_word(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s cyc %0d: got %h required %h", nm, cyc, got, exp);
        end
    endtask

    task automatic chk_port(input int id, input logic v, input logic [31:0] d);
        exp_t e;
        if (v === 1'b1) begin
            checks++;
            if (qs[id].size() == 0) begin
                errs++;
                $display("FAIL rvalid_q%0d cyc %0d: got rvalid=1 data=%h required rvalid=0", id, cyc, d);
            end else begin
                e = qs[id].pop_front();
                if (e.due != cyc || (e.chk && d !== e.dat)) begin
                    errs++;
                    $display("FAIL rdata_q%0d cyc %0d: got %h required %h at cyc %0d", id, cyc, d, e.dat, e.due);
                end
            end
        end else if (qs[id].size() != 0 && qs[id][0].due <= cyc) begin
            checks++;
            errs++;
            e = qs[id].pop_front();
            $display("FAIL rvalid_q%0d cyc %0d: got rvalid=%b required 1 (data %h)", id, cyc, v, e.dat);
        end
    endtask

    always @(negedge clk) begin
        if (rst_seen) begin
            chk_bit("ready_wf", wf_ready, cyc >= rst_cyc + 16);
            chk_bit("ready_rf", rf_ready, cyc >= rst_cyc + 16);
            chk_bit("ready_c", c_ready, cyc >= rst_cyc + 12);
            if (cyc == rst_cyc) begin
                chk_word("rst_a_rdata", wf_ard, 32'h0);
                chk_word("rst_b_rdata", wf_brd, 32'h0);
                chk_bit("rst_collision", wf_coll, 1'b0);
            end
            chk_port(0, wf_arv, wf_ard);
            chk_port(1, wf_brv, wf_brd);
            chk_port(2, rf_arv, rf_ard);
            chk_port(3, rf_brv, rf_brd);
            chk_port(4, c_arv, c_ard);
            chk_port(5, c_brv, c_brd);
            if (wf_coll === 1'b1 || rf_coll === 1'b1 || (coll_q.size() != 0 && coll_q[0] == cyc)) begin
                chk_bit("collision_wf", wf_coll, coll_q.size() != 0 && coll_q[0] == cyc);
                chk_bit("collision_rf", rf_coll, coll_q.size() != 0 && coll_q[0] == cyc);
                if (coll_q.size() != 0 && coll_q[0] == cyc) void'(coll_q.pop_front());
            end
        end
        if (done) begin
            for (int id = 0; id < 6; id++) begin
                checks++;
                if (qs[id].size() != 0) begin
                    errs++;
                    $display("FAIL drain_q%0d: got %0d reads outstanding required 0", id, qs[id].size());
                end
            end
            checks++;
            if (coll_q.size() != 0) begin
                errs++;
                $display("FAIL drain_collision: got %0d pulses outstanding required 0", coll_q.size());
            end
            $display("Result: errors=%0d of %0d checks", errs, checks);
            $finish;
        end
    end

endmodule
